// File: rtl/mat4_vec4_seq_pkg.sv
// Shared types and helpers for the 4x4 matrix times 4-vector sequencer (Q8.8 signed).
package mat4_vec4_seq_pkg;

  localparam int unsigned Q_W   = 16;
  localparam int unsigned VEC_N = 4;
  localparam int unsigned ROW_W = 2;

  localparam logic [Q_W-1:0] FIX_ONE = 16'h0100;

  // m[r][c] lands at bits (r*4+c)*16, matching the flat row-major bus
  typedef logic [VEC_N-1:0][Q_W-1:0]            vec4_t;
  typedef logic [VEC_N-1:0][VEC_N-1:0][Q_W-1:0] mat4_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Q8.8 x Q8.8 product, keeping bits [23:8] of the full signed result
  function automatic logic [Q_W-1:0] q88_mul(input logic signed [Q_W-1:0] a,
                                             input logic signed [Q_W-1:0] b);
    logic signed [2*Q_W-1:0] ae;
    logic signed [2*Q_W-1:0] be;
    logic signed [2*Q_W-1:0] p;
    ae = (2*Q_W)'(a);
    be = (2*Q_W)'(b);
    p  = ae * be;
    return p[Q_W+7:8];
  endfunction

endpackage

// File: rtl/mat4_vec4_seq_dot4.sv
// Shared dot4 engine: accumulates one Q8.8 term per cycle, pulses done with the wrapped sum.
module mat4_vec4_seq_dot4
  import mat4_vec4_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  vec4_t          a,
  input  vec4_t          b,
  output logic           done,
  output logic [Q_W-1:0] result
);

  logic [ROW_W-1:0] idx;
  logic             run;
  logic [Q_W-1:0]   acc;
  logic [Q_W-1:0]   term_c;

  assign term_c = q88_mul(a[idx], b[idx]);

  // Operands are held stable by the caller for the whole run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      run    <= 1'b0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        idx <= '0;
        acc <= '0;
      end else if (run) begin
        acc <= acc + term_c;
        idx <= idx + 1'b1;
        if (idx == ROW_W'(VEC_N - 1)) begin
          run    <= 1'b0;
          done   <= 1'b1;
          result <= acc + term_c;
        end
      end
    end
  end

endmodule

// File: rtl/mat4_vec4_seq.sv
// Vertex transform sequencer: out = M * v, one dot4 per row on a single shared engine.
module mat4_vec4_seq
  import mat4_vec4_seq_pkg::*;
#(
  parameter int unsigned    N_ROWS = 4,
  parameter logic [15:0]    W_FILL = 16'h0100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] m_flat,
  input  logic [63:0]  v_flat,
  output logic         busy,
  output logic         done,
  output logic [15:0]  out_x,
  output logic [15:0]  out_y,
  output logic [15:0]  out_z,
  output logic [15:0]  out_w
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  state_t           state;
  logic [ROW_W-1:0] row;
  mat4_t            m_lat;
  vec4_t            v_lat;
  vec4_t            out_r;
  vec4_t            row_a_c;
  logic             dot_start_c;
  logic             dot_done;
  logic [Q_W-1:0]   dot_result;

  // Operands come only from the latched copies, so they stay put through the dot4 run
  assign row_a_c     = m_lat[row];
  assign dot_start_c = (state == ST_ISSUE);

  mat4_vec4_seq_dot4 u_dot4 (
    .clk    (clk),
    .rst    (~rst_n),
    .start  (dot_start_c),
    .a      (row_a_c),
    .b      (v_lat),
    .done   (dot_done),
    .result (dot_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      row   <= '0;
      m_lat <= '0;
      v_lat <= '0;
      out_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            m_lat <= m_flat;
            v_lat <= v_flat;
            row   <= '0;
            busy  <= 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (dot_done) begin
            out_r[row] <= dot_result;
            if (row == LAST_ROW) begin
              // xyz-only builds report a constant homogeneous w
              if (N_ROWS == 3) out_r[3] <= W_FILL;
              state <= ST_FIN;
            end else begin
              row   <= row + 1'b1;
              state <= ST_ISSUE;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_x = out_r[0];
  assign out_y = out_r[1];
  assign out_z = out_r[2];
  assign out_w = out_r[3];

endmodule

// File: tb/tb_mat4_vec4_seq.sv
// Bench for mat4_vec4_seq: directed and random jobs against an arithmetic reference model.
module tb_mat4_vec4_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start4, start3;
  logic [255:0] m4, m3;
  logic [63:0]  v4, v3;
  logic         busy4, done4, busy3, done3;
  logic [15:0]  x4, y4, z4, w4, x3, y3, z3, w3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mat4_vec4_seq #(.N_ROWS(4), .W_FILL(16'h0100)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .m_flat(m4), .v_flat(v4),
    .busy(busy4), .done(done4), .out_x(x4), .out_y(y4), .out_z(z4), .out_w(w4)
  );

  mat4_vec4_seq #(.N_ROWS(3), .W_FILL(16'h0100)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .m_flat(m3), .v_flat(v3),
    .busy(busy3), .done(done3), .out_x(x3), .out_y(y3), .out_z(z3), .out_w(w3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // out[r] = sum_c floor(m[r][c]*v[c] / 256), wrapped to 16 bits
  function automatic logic [63:0] model(input logic [255:0] m, input logic [63:0] v, input int rows);
    logic [63:0] res;
    res = '0;
    for (int r = 0; r < rows; r++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
        int p;
        p = int'($signed(m[(r*4+c)*16 +: 16])) * int'($signed(v[c*16 +: 16]));
        acc += p >>> 8;
      end
      res[r*16 +: 16] = acc[15:0];
    end
    if (rows == 3) res[63:48] = 16'h0100;
    return res;
  endfunction

  function automatic logic [255:0] identity_m();
    logic [255:0] m;
    m = '0;
    for (int r = 0; r < 4; r++) m[(r*5)*16 +: 16] = 16'h0100;
    return m;
  endfunction

  function automatic logic [255:0] rand_m();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [63:0] rand_v();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  function automatic logic [63:0] outs(input bit d3);
    return d3 ? {w3, z3, y3, x3} : {w4, z4, y4, x4};
  endfunction

  // Launch one job, watch for exactly one done pulse, compare captured and held outputs
  task automatic do_job(input bit d3, input logic [255:0] m, input logic [63:0] v,
                        input logic [63:0] exp, input bit chaos, input string tag);
    int          ndone;
    bit          seen;
    logic [63:0] got;
    ndone = 0;
    seen  = 1'b0;
    got   = '0;
    if (d3) begin m3 = m; v3 = v; start3 = 1'b1; end
    else    begin m4 = m; v4 = v; start4 = 1'b1; end
    @(negedge clk);
    start3 = 1'b0;
    start4 = 1'b0;
    check({tag, "_busy_on"}, 64'(d3 ? busy3 : busy4), 64'(1));
    for (int i = 0; i < 80 && !(seen && !(d3 ? busy3 : busy4)); i++) begin
      if (chaos && !d3 && busy4 && !done4) begin
        start4 = 1'($urandom_range(0, 1));
        m4 = rand_m();
        v4 = rand_v();
      end else begin
        start4 = 1'b0;
        start3 = 1'b0;
      end
      @(negedge clk);
      if (d3 ? done3 : done4) begin
        ndone++;
        if (!seen) got = outs(d3);
        seen = 1'b1;
      end
    end
    start4 = 1'b0;
    start3 = 1'b0;
    check({tag, "_ndone"}, 64'(ndone), 64'(1));
    check({tag, "_result"}, got, exp);
    check({tag, "_busy_off"}, 64'(d3 ? busy3 : busy4), 64'(0));
    @(negedge clk);
    check({tag, "_hold"}, outs(d3), exp);
  endtask

  initial begin
    logic [255:0] m;
    logic [63:0]  v;
    int           nd;

    rst_n  = 1'b0;
    start4 = 1'b0;
    start3 = 1'b0;
    m4 = '0; v4 = '0; m3 = '0; v3 = '0;
    repeat (2) @(negedge clk);
    check("reset_outs4", outs(1'b0), 64'h0);
    check("reset_outs3", outs(1'b1), 64'h0);
    check("reset_flags", {62'h0, busy4, done4}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity matrix passes the vector through
    do_job(1'b0, identity_m(), 64'h0100_FD00_0200_0100, 64'h0100_FD00_0200_0100, 1'b0, "t1_identity");

    // Diagonal scale 2.0 with translation in column 3 of row 0
    m = '0;
    for (int r = 0; r < 4; r++) m[(r*5)*16 +: 16] = 16'h0200;
    m[3*16 +: 16] = 16'h0A00;
    do_job(1'b0, m, 64'h0100_0100_0100_0100, 64'h0200_0200_0200_0C00, 1'b0, "t2_scale_xlate");

    // 127.0 * 2.0 wraps to -2.0
    m = '0;
    m[15:0] = 16'h7F00;
    do_job(1'b0, m, 64'h0000_0000_0000_0200, 64'h0000_0000_0000_FE00, 1'b0, "t3_wrap");

    // Repeated start and input churn while busy: result follows the latched job
    m = rand_m();
    v = rand_v();
    do_job(1'b0, m, v, model(m, v, 4), 1'b1, "t4_churn");

    // Reset asserted during row 2's dot4 run
    m4 = identity_m();
    v4 = 64'h0400_0300_0200_0100;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_pre_busy", 64'(busy4), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", outs(1'b0), 64'h0);
    check("t5_rst_flags", {62'h0, busy4, done4}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4 || busy4) nd++;
    end
    check("t5_no_done", 64'(nd), 64'(0));
    m = rand_m();
    v = rand_v();
    do_job(1'b0, m, v, model(m, v, 4), 1'b0, "t5_after");

    // xyz-only build: w forced to 1.0, back-to-back jobs
    do_job(1'b1, identity_m(), 64'h0500_FD00_0200_0100, 64'h0100_FD00_0200_0100, 1'b0, "t6_xyz");
    for (int k = 0; k < 3; k++) begin
      m = rand_m();
      v = rand_v();
      do_job(1'b1, m, v, model(m, v, 3), 1'b0, $sformatf("t6_b2b%0d", k));
    end

    // Random full transforms, back-to-back
    for (int k = 0; k < 6; k++) begin
      m = rand_m();
      v = rand_v();
      do_job(1'b0, m, v, model(m, v, 4), 1'(k % 2), $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
